// File: rtl/delay_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : delay_timer_pkg
//  Description : Shared timing definitions for the entry timing path.
//                - mode encodings for the delay timer
//                - helper for sizing the prescaler counter
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package delay_timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Bits needed to hold 0..p-1, never less than one so the prescaler
  // register always has a legal declaration.
  function automatic int pre_width(input int p);
    if (p <= 2) begin
      return 1;
    end
    return $clog2(p);
  endfunction

endpackage : delay_timer_pkg
`default_nettype wire

// File: rtl/delay_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_prescaler
//  Description : Divides the clock into count steps for delay_timer.
//                Emits a one-cycle step every PRESCALE running cycles.
//  Ports       : clock   - system clock, rising edge
//                clear_n - asynchronous active-low reset
//                restart - synchronous restart of the phase counter
//                run     - counting enabled
//                step    - step qualifier for the current cycle
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module timer_prescaler
  import delay_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic clear_n,
  input  logic restart,
  input  logic run,
  output logic step
);

  localparam int            c_pw   = pre_width(PRESCALE);
  localparam logic [c_pw-1:0] c_last = c_pw'(PRESCALE - 1);

  logic [c_pw-1:0] r_pre;
  logic            w_hit;

  // With PRESCALE=1 c_last is 0 and r_pre never leaves 0, so the register
  // collapses to a constant and step reduces to run.
  assign w_hit = (r_pre == c_last);
  assign step  = run & w_hit & ~restart;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_pre <= '0;
    end else if (restart) begin
      r_pre <= '0;
    end else if (run) begin
      if (w_hit) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/delay_timer.sv
`default_nettype none
// ============================================================================
//  Module      : delay_timer
//  Description : Programmable delay timer for the entry timing path.
//                Counts prescaled ticks after start; one-shot mode raises a
//                sticky expired flag and saturates, periodic mode emits a
//                tick and auto-reloads.
//  Ports       : clock     - system clock, rising edge
//                clear_n   - asynchronous active-low reset
//                start     - restart timer, latch threshold and mode
//                stop      - halt counting, hold count and expired
//                mode      - 0 one-shot, 1 periodic (latched at start)
//                threshold - target count, 0 treated as 1 (latched at start)
//                count     - current count
//                expired   - one-shot threshold reached (sticky)
//                tick      - one-cycle pulse when count reaches threshold
//                busy      - timer active
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module delay_timer
  import delay_timer_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] count,
  output logic             expired,
  output logic             tick,
  output logic             busy
);

  localparam logic [WIDTH-1:0] c_all_ones = '1;
  localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_expired;
  logic             r_tick;
  logic             r_busy;
  logic             r_run;
  logic [WIDTH-1:0] r_thr;
  logic             r_mode;

  logic [WIDTH-1:0] w_count;
  logic             w_expired;
  logic             w_tick;
  logic             w_busy;
  logic             w_run;
  logic [WIDTH-1:0] w_thr;
  logic             w_mode;
  logic             w_step;
  logic             w_restart;
  logic             w_at_thr;

  // A start that loses to stop must not disturb the prescaler phase.
  assign w_restart = start & ~stop;

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .clear_n (clear_n),
    .restart (w_restart),
    .run     (r_run),
    .step    (w_step)
  );

  assign w_at_thr = (r_count == (r_thr - 1'b1));

  always_comb begin
    w_count   = r_count;
    w_expired = r_expired;
    w_tick    = 1'b0;
    w_run     = r_run;
    w_thr     = r_thr;
    w_mode    = r_mode;

    if (stop) begin
      w_run = 1'b0;
    end else if (start) begin
      w_count   = '0;
      w_expired = 1'b0;
      w_run     = 1'b1;
      w_thr     = (threshold == '0) ? c_one : threshold;
      w_mode    = mode;
    end else if (w_step) begin
      if (w_at_thr) begin
        w_tick = 1'b1;
        if (r_mode == MODE_PERIODIC) begin
          w_count = '0;
        end else begin
          w_count   = r_count + 1'b1;
          w_expired = 1'b1;
        end
      end else if (r_mode == MODE_PERIODIC) begin
        w_count = r_count + 1'b1;
      end else if (r_count != c_all_ones) begin
        // One-shot saturates at all-ones; the threshold match can never
        // recur because thr-1 is always below all-ones.
        w_count = r_count + 1'b1;
      end
    end

    // busy is derived from next state so it agrees with the other
    // registered outputs on the same edge.
    w_busy = w_run & ((w_mode == MODE_PERIODIC) | ~w_expired);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_count   <= '0;
      r_expired <= 1'b0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
      r_run     <= 1'b0;
      r_thr     <= c_one;
      r_mode    <= MODE_ONESHOT;
    end else begin
      r_count   <= w_count;
      r_expired <= w_expired;
      r_tick    <= w_tick;
      r_busy    <= w_busy;
      r_run     <= w_run;
      r_thr     <= w_thr;
      r_mode    <= w_mode;
    end
  end

  assign count   = r_count;
  assign expired = r_expired;
  assign tick    = r_tick;
  assign busy    = r_busy;

endmodule : delay_timer
`default_nettype wire

// File: tb/tb_delay_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_timer
//  Description : Directed self-checking bench for delay_timer.
//                Three instances: legacy (W3,P1), periodic (W4,P1),
//                prescaled (W4,P3). Inputs change and outputs are sampled
//                on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_timer;

  logic clock;
  logic clear_n;

  logic       a_start, a_stop, a_mode;
  logic [2:0] a_thr, a_count;
  logic       a_exp, a_tick, a_busy;

  logic       b_start, b_stop, b_mode;
  logic [3:0] b_thr, b_count;
  logic       b_exp, b_tick, b_busy;

  logic       c_start, c_stop, c_mode;
  logic [3:0] c_thr, c_count;
  logic       c_exp, c_tick, c_busy;

  int n_total;
  int n_bad;

  delay_timer #(.WIDTH(3), .PRESCALE(1)) u_a (
    .clock(clock), .clear_n(clear_n), .start(a_start), .stop(a_stop),
    .mode(a_mode), .threshold(a_thr), .count(a_count), .expired(a_exp),
    .tick(a_tick), .busy(a_busy)
  );

  delay_timer #(.WIDTH(4), .PRESCALE(1)) u_b (
    .clock(clock), .clear_n(clear_n), .start(b_start), .stop(b_stop),
    .mode(b_mode), .threshold(b_thr), .count(b_count), .expired(b_exp),
    .tick(b_tick), .busy(b_busy)
  );

  delay_timer #(.WIDTH(4), .PRESCALE(3)) u_c (
    .clock(clock), .clear_n(clear_n), .start(c_start), .stop(c_stop),
    .mode(c_mode), .threshold(c_thr), .count(c_count), .expired(c_exp),
    .tick(c_tick), .busy(c_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int req);
    n_total++;
    if (obs != req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, req);
    end
  endtask

  task automatic chk_a(input string tag, input int cnt, input int ex,
                       input int tk, input int bz);
    chk({tag, ".count"},   int'(a_count), cnt);
    chk({tag, ".expired"}, int'(a_exp),   ex);
    chk({tag, ".tick"},    int'(a_tick),  tk);
    chk({tag, ".busy"},    int'(a_busy),  bz);
  endtask

  // One falling-to-falling cycle: exactly one rising edge in between.
  task automatic cyc();
    @(negedge clock);
  endtask

  // Pulse start on instance A for one edge.
  task automatic start_a(input logic [2:0] t);
    a_thr   = t;
    a_mode  = 1'b0;
    a_start = 1'b1;
    cyc();
    a_start = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    clear_n = 1'b0;
    a_start = 0; a_stop = 0; a_mode = 0; a_thr = 3'd0;
    b_start = 0; b_stop = 0; b_mode = 0; b_thr = 4'd0;
    c_start = 0; c_stop = 0; c_mode = 0; c_thr = 4'd0;

    // ---------------- reset state
    cyc(); cyc();
    chk_a("rst", 0, 0, 0, 0);
    chk("rst.b_count", int'(b_count), 0);
    chk("rst.c_busy",  int'(c_busy),  0);
    clear_n = 1'b1;
    cyc();
    chk_a("idle", 0, 0, 0, 0);

    // ---------------- legacy one-shot W3 P1 T4
    start_a(3'd4);
    chk_a("leg.s", 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk_a($sformatf("leg%0d", i), (i < 7) ? i : 7, (i >= 4) ? 1 : 0,
            (i == 4) ? 1 : 0, (i < 4) ? 1 : 0);
    end

    // ---------------- periodic W4 P1 T3
    b_thr = 4'd3; b_mode = 1'b1; b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    chk("per.s.count", int'(b_count), 0);
    chk("per.s.busy",  int'(b_busy),  1);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk($sformatf("per%0d.count", i),   int'(b_count), i % 3);
      chk($sformatf("per%0d.tick", i),    int'(b_tick),  (i % 3 == 0) ? 1 : 0);
      chk($sformatf("per%0d.expired", i), int'(b_exp),   0);
      chk($sformatf("per%0d.busy", i),    int'(b_busy),  1);
    end

    // ---------------- prescaled one-shot W4 P3 T2
    c_thr = 4'd2; c_mode = 1'b0; c_start = 1'b1;
    cyc();
    c_start = 1'b0;
    chk("pre.s.count", int'(c_count), 0);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      chk($sformatf("pre%0d.count", i),   int'(c_count), i / 3);
      chk($sformatf("pre%0d.expired", i), int'(c_exp),   (i >= 6) ? 1 : 0);
      chk($sformatf("pre%0d.tick", i),    int'(c_tick),  (i == 6) ? 1 : 0);
      chk($sformatf("pre%0d.busy", i),    int'(c_busy),  (i < 6) ? 1 : 0);
    end

    // ---------------- stop at count 2
    start_a(3'd4);
    cyc(); cyc();
    chk_a("stop.pre", 2, 0, 0, 1);
    a_stop = 1'b1;
    cyc();
    a_stop = 1'b0;
    chk_a("stop.e", 2, 0, 0, 0);
    cyc(); cyc();
    chk_a("stop.hold", 2, 0, 0, 0);

    // ---------------- start and stop together: stop wins
    a_stop = 1'b1; a_start = 1'b1; a_thr = 3'd1;
    cyc();
    a_stop = 1'b0; a_start = 1'b0;
    chk_a("ss", 2, 0, 0, 0);
    cyc();
    chk_a("ss.hold", 2, 0, 0, 0);

    // ---------------- threshold 0 treated as 1
    start_a(3'd0);
    chk_a("t0.s", 0, 0, 0, 1);
    cyc();
    chk_a("t0.1", 1, 1, 1, 0);
    cyc();
    chk_a("t0.2", 2, 1, 0, 0);

    // ---------------- threshold latching
    start_a(3'd5);
    cyc();
    chk_a("lat1", 1, 0, 0, 1);
    a_thr = 3'd2;
    cyc();
    chk_a("lat2", 2, 0, 0, 1);
    cyc(); cyc();
    chk_a("lat4", 4, 0, 0, 1);
    cyc();
    chk_a("lat5", 5, 1, 1, 0);

    // ---------------- async reset between edges, right after a tick edge
    start_a(3'd2);
    cyc(); cyc();
    chk_a("ar.pre", 2, 1, 1, 0);
    chk("ar.pre.b_busy", int'(b_busy), 1);
    #2;
    clear_n = 1'b0;
    #1;
    chk_a("ar.now", 0, 0, 0, 0);
    chk("ar.now.b_count", int'(b_count), 0);
    chk("ar.now.b_busy",  int'(b_busy),  0);
    chk("ar.now.c_count", int'(c_count), 0);
    chk("ar.now.c_expired", int'(c_exp), 0);
    cyc();
    clear_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk_a($sformatf("ar.idle%0d", i), 0, 0, 0, 0);
      chk($sformatf("ar.idle%0d.b_count", i), int'(b_count), 0);
    end

    // ---------------- after reset, count resumes only on start
    start_a(3'd3);
    cyc();
    chk_a("ar.restart", 1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard bound in case the stimulus ever stalls.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_delay_timer
`default_nettype wire
